avalon_pio_in_irq: RTL and testbench
====================================

# avalon_pio_in_irq

Parametrised Avalon-MM input PIO with per-bit edge capture, interrupt mask and a registered interrupt request. It is the next-generation input port for HPS-attached buttons and switches. Over the fixed 16-bit rising-edge port it adds:
- configurable width and edge polarity;
- a two-flop input synchroniser;
- write-1-to-clear capture bits;
- an IRQ line;
- an optional debounce filter.

## Interface
Parameters:
- WIDTH, 16, number of input bits (1..32); readdata zero-extended above WIDTH.
- EDGE_TYPE, 0, capture condition: 0 rising, 1 falling, 2 any.
- BIT_CLEARING, 1, 1 = write-1-to-clear per capture bit; 0 = any write to address 3 clears all bits.
- DEBOUNCE_CYCLES, 4, required stable cycles (>=2). Used only with the debounce macro.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  registered level interrupt.

## Operation
- Register map:
  - 0: data, read-only, the filtered input value.
  - 1: reserved, reads 0, writes ignored.
  - 2: irq_mask, R/W, WIDTH bits.
  - 3: edge_capture, read and clear.
- Synchroniser: s1 <= in_port; s2 <= s1.
- filt:
  - Without debounce, filt = s2.
  - prev <= filt every cycle.
- Edge detect per bit:
  - rising: filt & ~prev.
  - falling: ~filt & prev.
  - any: filt ^ prev.
- Capture bit set: when its edge detect is 1, the bit becomes 1 and holds until cleared.
- Clear:
  - With BIT_CLEARING=1, a write to address 3 clears the bits where writedata is 1.
  - With BIT_CLEARING=0, a write to address 3 clears all bits.
- Simultaneous clear and edge on the same bit: the edge wins and the bit ends at 1.
- irq <= |(edge_capture & irq_mask), evaluated every cycle.
- Writes to address 0 and 1 have no effect.
- Writes to address 2 load writedata[WIDTH-1:0] into irq_mask.
- readdata is reloaded every cycle from the address mux, regardless of chipselect.

## Timing
- Reset (reset_n=0 at a clk edge) zeroes s1, s2, prev, filt, debounce counters, edge_capture, irq_mask, readdata and irq.
- Reset asserted mid-operation discards pending edges; no capture is generated from pre-reset state on release.
- Read latency is 1 cycle: readdata is valid on the cycle after the address is presented.
- Input path without debounce, for an in_port change before edge k:
  - s2 updates at edge k+1.
  - the capture bit sets at edge k+2.
  - irq asserts at edge k+3 if the bit is masked in.
- A mask write takes effect on irq one cycle after the write edge.
- A clear takes effect on irq one cycle after the write edge.
- Input pulses shorter than one clk period may be missed; there is no requirement to catch them.

## Configuration
- Macro: AVALON_PIO_IN_DEBOUNCE_EN.
- Defined:
  - Each bit has a counter of width $clog2(DEBOUNCE_CYCLES).
  - While s2 differs from filt, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with s2 still differing, filt <= s2 and the counter returns to 0.
  - Whenever s2 equals filt, the counter returns to 0.
  - Net effect: filt follows s2 only after s2 has held a new value for DEBOUNCE_CYCLES consecutive cycles, which adds DEBOUNCE_CYCLES cycles of latency.
- Undefined: filt = s2 combinationally, and no counters are instantiated.

## Structure
- Package pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3;
  - EDGE_TYPE encodings EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module pio_debounce_bit: one bit of counter plus filt register, instantiated WIDTH times under the macro.

## Test plan
- Reset, then read each address → readdata is 0 for all four; irq stays 0.
- WIDTH=16, EDGE_TYPE=0: in_port goes 0x0000 → 0x0005, then read address 3 → 0x00000005; read address 0 → 0x00000005.
- irq_mask=0x0004, edge_capture=0x0005:
  - irq=1 three cycles after the input change.
  - write 0x0004 to address 3 → edge_capture=0x0001 and irq deasserts one cycle later.
- EDGE_TYPE=2, in_port bit 3 toggles 1 → 0 → edge_capture[3]=1; with EDGE_TYPE=1 the same stimulus also sets it, and 0 → 1 does not.
- Write 0x1 to address 3 in the same cycle bit 0 edge detect fires → edge_capture[0] remains 1.
- With macro, DEBOUNCE_CYCLES=4:
  - a 3-cycle pulse on bit 0 → data and edge_capture unchanged;
  - a 4-cycle hold → data bit 0 = 1 and edge_capture[0]=1.

Source files
------------

// File: rtl/avalon_pio_in_irq_pkg.sv
// Shared constants for the Avalon-MM input PIO: register addresses and
// edge-type encodings.
package pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 32'd0;
  localparam int EDGE_FALL = 32'd1;
  localparam int EDGE_ANY  = 32'd2;

endpackage

// File: rtl/avalon_pio_in_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO (32-bit data, word addressed).
interface avalon_pio_in_irq_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/avalon_pio_in_irq_debounce_bit.sv
// Single-bit debounce filter: filt follows s2 only after DEBOUNCE_CYCLES stable
// cycles. Only present when AVALON_PIO_IN_DEBOUNCE_EN is defined.
`ifdef AVALON_PIO_IN_DEBOUNCE_EN
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic s2_i,
  output logic filt_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Counter and filtered-value registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  // Count consecutive cycles of disagreement; adopt s2 on the last one.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (s2_i == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      filt_d = s2_i;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign filt_o = filt_q;

endmodule
`endif

// File: rtl/avalon_pio_in_irq.sv
// Avalon-MM input PIO with edge capture, IRQ mask and registered IRQ.
// Optional per-bit debounce filter enabled by AVALON_PIO_IN_DEBOUNCE_EN.
module avalon_pio_in_irq
  import pio_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int EDGE_TYPE       = 0,
  parameter int BIT_CLEARING    = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  avalon_pio_in_irq_if.slave   bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
    $error("avalon_pio_in_irq: unsupported WIDTH or DEBOUNCE_CYCLES");
  end

  logic [WIDTH-1:0] s1_q, s2_q, prev_q, filt_s, edge_s, clr_s;
  logic [WIDTH-1:0] cap_q, cap_d, mask_q, mask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;
  logic             wr_s;
  logic             unused_wdata_s;

  assign unused_wdata_s = ^bus.writedata;

`ifdef AVALON_PIO_IN_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    pio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .s2_i    (s2_q[i]),
      .filt_o  (filt_s[i])
    );
  end
`else
  assign filt_s = s2_q;
`endif

  // Synchroniser, edge history and register file state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      cap_q   <= '0;
      mask_q  <= '0;
      rdata_q <= 32'd0;
      irq_q   <= 1'b0;
    end else begin
      s1_q    <= in_port;
      s2_q    <= s1_q;
      prev_q  <= filt_s;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  // Edge detection for the configured polarity.
  always_comb begin
    edge_s = filt_s & ~prev_q;
    case (EDGE_TYPE)
      EDGE_RISE: edge_s = filt_s & ~prev_q;
      EDGE_FALL: edge_s = ~filt_s & prev_q;
      EDGE_ANY:  edge_s = filt_s ^ prev_q;
      default:   edge_s = filt_s & ~prev_q;
    endcase
  end

  // Bus writes: mask load and capture clear; a fresh edge beats a clear.
  always_comb begin
    wr_s   = bus.chipselect & ~bus.write_n;
    mask_d = mask_q;
    clr_s  = '0;
    if (wr_s && (bus.address == ADDR_MASK)) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_s && (bus.address == ADDR_EDGE)) begin
      if (BIT_CLEARING != 0) begin
        clr_s = bus.writedata[WIDTH-1:0];
      end else begin
        clr_s = '1;
      end
    end else begin
      clr_s = '0;
    end
    cap_d = (cap_q & ~clr_s) | edge_s;
    irq_d = |(cap_q & mask_q);
  end

  // Read mux, reloaded every cycle independent of chipselect.
  always_comb begin
    rdata_d = 32'd0;
    case (bus.address)
      ADDR_DATA: rdata_d[WIDTH-1:0] = filt_s;
      ADDR_RSVD: rdata_d = 32'd0;
      ADDR_MASK: rdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: rdata_d[WIDTH-1:0] = cap_q;
      default:   rdata_d = 32'd0;
    endcase
  end

  assign bus.readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_avalon_pio_in_irq.sv
// Scoreboard bench: three PIO instances (rising/bit-clear, any/bit-clear,
// falling/clear-all) share one bus and input port.
module tb_avalon_pio_in_irq;

`ifdef AVALON_PIO_IN_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [31:0] wdata = 32'd0;
  logic [15:0] in_port = 16'd0;
  logic        irq_r, irq_a, irq_f;

  avalon_pio_in_irq_if bus_r ();
  avalon_pio_in_irq_if bus_a ();
  avalon_pio_in_irq_if bus_f ();

  assign bus_r.address = addr;  assign bus_r.chipselect = cs;
  assign bus_r.write_n = wn;    assign bus_r.writedata  = wdata;
  assign bus_a.address = addr;  assign bus_a.chipselect = cs;
  assign bus_a.write_n = wn;    assign bus_a.writedata  = wdata;
  assign bus_f.address = addr;  assign bus_f.chipselect = cs;
  assign bus_f.write_n = wn;    assign bus_f.writedata  = wdata;

  avalon_pio_in_irq #(.WIDTH(16), .EDGE_TYPE(0), .BIT_CLEARING(1), .DEBOUNCE_CYCLES(4)) dut_r (
    .clk(clk), .reset_n(reset_n), .bus(bus_r), .in_port(in_port), .irq(irq_r));
  avalon_pio_in_irq #(.WIDTH(16), .EDGE_TYPE(2), .BIT_CLEARING(1), .DEBOUNCE_CYCLES(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_port), .irq(irq_a));
  avalon_pio_in_irq #(.WIDTH(16), .EDGE_TYPE(1), .BIT_CLEARING(0), .DEBOUNCE_CYCLES(4)) dut_f (
    .clk(clk), .reset_n(reset_n), .bus(bus_f), .in_port(in_port), .irq(irq_f));

  always #5 clk = ~clk;

  // Scoreboard: kind 0 = readdata, kind 1 = irq; dut 0/1/2 = r/a/f.
  int          kind_q[$];
  int          dut_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          chk_n = 0;
  int          pend_n = 0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [31:0] actual(input int kind, input int d);
    if (kind == 0) begin
      if (d == 0) return bus_r.readdata;
      else if (d == 1) return bus_a.readdata;
      else return bus_f.readdata;
    end else begin
      if (d == 0) return {31'd0, irq_r};
      else if (d == 1) return {31'd0, irq_a};
      else return {31'd0, irq_f};
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      pend_n = chk_n;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < pend_n; k++) begin
        if (kind_q.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard_underflow actual=empty required=entry");
        end else begin
          int          kd, dd;
          logic [31:0] ev, av;
          string       nm;
          kd = kind_q.pop_front(); dd = dut_q.pop_front();
          ev = exp_q.pop_front();  nm = name_q.pop_front();
          av = actual(kd, dd);
          total++;
          if (av !== ev) begin
            bad++;
            $display("FAIL %s dut=%0d actual=0x%08h required=0x%08h", nm, dd, av, ev);
          end
        end
      end
      pend_n = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk_n = 0;
    cs = 1'b0;
    wn = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push_exp(input int kind, input int d, input logic [31:0] e, input string nm);
    kind_q.push_back(kind); dut_q.push_back(d);
    exp_q.push_back(e);     name_q.push_back(nm);
    chk_n++;
  endtask

  task automatic rd(input int d, input logic [1:0] a, input logic [31:0] e, input string nm);
    step();
    addr = a; cs = 1'b1; wn = 1'b1;
    push_exp(0, d, e, nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step();
    addr = a; cs = 1'b1; wn = 1'b0; wdata = d;
  endtask

  initial begin
    idle(3);
    step(); reset_n = 1'b1;
    idle(2);

    rd(0, 2'd0, 32'd0, "reset_data");
    rd(0, 2'd1, 32'd0, "reset_rsvd");
    rd(0, 2'd2, 32'd0, "reset_mask");
    rd(0, 2'd3, 32'd0, "reset_edge");
    push_exp(1, 0, 32'd0, "reset_irq");

    wr(2'd2, 32'h0000_0004);
    rd(0, 2'd2, 32'h0000_0004, "mask_readback");

    // Rising edges on bits 0 and 2; irq three cycles (plus filter) later.
    step(); in_port = 16'h0005;
    for (int j = 1; j <= 3 + DB; j++) begin
      step();
      if (j == 2 + DB) begin
        push_exp(1, 0, 32'd0, "irq_not_yet");
        push_exp(1, 2, 32'd0, "irq_fall_quiet");
      end
      if (j == 3 + DB) begin
        push_exp(1, 0, 32'd1, "irq_asserts");
        push_exp(1, 1, 32'd1, "irq_any_asserts");
        push_exp(1, 2, 32'd0, "irq_fall_none");
      end
    end
    rd(0, 2'd3, 32'h0000_0005, "edge_rise");
    rd(0, 2'd0, 32'h0000_0005, "data_value");
    rd(1, 2'd3, 32'h0000_0005, "edge_any_rise");
    rd(2, 2'd3, 32'h0000_0000, "edge_fall_on_rise");

    // Clear bit 2: irq holds one more cycle, then drops.
    wr(2'd3, 32'h0000_0004);
    push_exp(1, 0, 32'd1, "irq_before_clear");
    step();
    push_exp(1, 0, 32'd0, "irq_after_clear");
    rd(0, 2'd3, 32'h0000_0001, "edge_partial_clear");

    wr(2'd1, 32'h0000_1234);
    wr(2'd0, 32'h0000_FFFF);
    rd(0, 2'd1, 32'd0, "rsvd_write_ignored");
    rd(0, 2'd0, 32'h0000_0005, "data_write_ignored");
    rd(0, 2'd2, 32'h0000_0004, "mask_unchanged");

    // Bit 3 rises, then falls.
    wr(2'd3, 32'h0000_FFFF);
    step(); in_port = 16'h000D;
    idle(6 + DB);
    rd(0, 2'd3, 32'h0000_0008, "bit3_rise_rising");
    rd(1, 2'd3, 32'h0000_0008, "bit3_rise_any");
    rd(2, 2'd3, 32'h0000_0000, "bit3_rise_falling");
    wr(2'd3, 32'h0000_FFFF);
    step(); in_port = 16'h0005;
    idle(6 + DB);
    rd(0, 2'd3, 32'h0000_0000, "bit3_fall_rising");
    rd(1, 2'd3, 32'h0000_0008, "bit3_fall_any");
    rd(2, 2'd3, 32'h0000_0008, "bit3_fall_falling");

    // Clear-all instance ignores writedata; bit-clear instance honours it.
    wr(2'd3, 32'h0000_0001);
    rd(1, 2'd3, 32'h0000_0008, "bitclear_keeps");
    rd(2, 2'd3, 32'h0000_0000, "clearall_clears");

    // Clear of bit 0 in the same cycle its edge fires.
    step(); in_port = 16'h0004;
    idle(6 + DB);
    wr(2'd3, 32'h0000_FFFF);
    step(); in_port = 16'h0005;
    idle(1 + DB);
    wr(2'd3, 32'h0000_0001);
    idle(2);
    rd(0, 2'd3, 32'h0000_0001, "edge_beats_clear");
    rd(1, 2'd3, 32'h0000_0001, "edge_beats_clear_any");

`ifdef AVALON_PIO_IN_DEBOUNCE_EN
    step(); in_port = 16'h0004;
    idle(10);
    wr(2'd3, 32'h0000_FFFF);
    step(); in_port = 16'h0005;
    idle(2);
    step(); in_port = 16'h0004;
    idle(10);
    rd(0, 2'd0, 32'h0000_0004, "db_short_data");
    rd(0, 2'd3, 32'h0000_0000, "db_short_edge");
    step(); in_port = 16'h0005;
    idle(10);
    rd(0, 2'd0, 32'h0000_0005, "db_hold_data");
    rd(0, 2'd3, 32'h0000_0001, "db_hold_edge");
`endif

    // Reset mid-operation clears the mask and irq.
    step(); reset_n = 1'b0;
    idle(2);
    step(); reset_n = 1'b1;
    rd(0, 2'd2, 32'd0, "post_reset_mask");
    push_exp(1, 0, 32'd0, "post_reset_irq");

    idle(3);
    if (kind_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", kind_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
